mac_result_fifo: RTL and testbench

- Output buffer directly downstream of the sum-of-squares accumulator stage.
- Captures the accumulator's 20-bit running-sum result on every `in_valid` pulse. The accumulator cannot be stalled, so words must be taken when offered.
- Presents the buffered results to the next consumer over a valid/ready handshake.
- Absorbs consumer stalls. Detects, flags and counts results lost to overflow.

---
 rtl/mac_result_fifo.sv | 59 +++++
 tb/tb_mac_result_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mac_result_fifo.sv
// mac_result_fifo: first-word-fall-through result buffer behind the accumulator,
// with a sticky overflow flag and a saturating count of dropped words.
module mac_result_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [DROPW-1:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [DROPW-1:0] r_drop_cnt;
    logic             w_rd, w_wr, w_drop;

    assign out_valid = r_count != '0;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign full      = r_count == (AW+1)'(DEPTH);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

    // a pop in the same cycle frees a slot, so a full FIFO still accepts
    assign w_rd   = out_valid & out_ready;
    assign w_wr   = in_valid & (~full | w_rd);
    assign w_drop = in_valid & full & ~w_rd;

    always_ff @(posedge clk)
        if (!reset && w_wr) r_mem[r_wr_ptr] <= in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            if (w_drop) r_overflow <= 1'b1;
            if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROPW'(1);
        end
    end
endmodule

// File: tb/tb_mac_result_fifo.sv
// tb_mac_result_fifo: vector table, directed corner sequences and a randomized
// run against a queue-based reference model.
module tb_mac_result_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [19:0] out_data;
    logic        out_valid;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    mac_result_fifo #(.WIDTH(20), .DEPTH(4), .DROPW(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [19:0] d;
        logic        rdy;
        logic        ev;
        logic [19:0] ed;
        logic [2:0]  ec;
        logic        eo;
        logic [7:0]  edr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [19:0] d, input logic rdy,
                       input logic ev, input logic [19:0] ed, input logic [2:0] ec,
                       input logic eo, input logic [7:0] edr);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy; v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.edr = edr;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [19:0] ed,
                           input logic [2:0] ec, input logic eo, input logic [7:0] edr);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " out_data"}, 32'(out_data), 32'(ed));
        chk({tag, " count"}, 32'(count), 32'(ec));
        chk({tag, " full"}, 32'(full), 32'(ec == 3'd4));
        chk({tag, " overflow"}, 32'(overflow), 32'(eo));
        chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(edr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [19:0] d, input logic rdy);
        reset = rst; in_valid = iv; in_data = d; out_ready = rdy;
    endtask

    logic [19:0] mq[$];
    logic        m_ovf;
    logic [7:0]  m_drop;

    initial begin
        drive(1, 1, 20'h12345, 1);
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0);

        add(1, 20'h19, 0, 1, 20'h19, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 20'h1, 0, 1, 20'h1, 1, 0, 0);
        add(1, 20'h5, 0, 1, 20'h1, 2, 0, 0);
        add(1, 20'hE, 0, 1, 20'h1, 3, 0, 0);
        add(1, 20'h1E, 0, 1, 20'h1, 4, 0, 0);
        add(0, 0, 1, 1, 20'h5, 3, 0, 0);
        add(0, 0, 1, 1, 20'hE, 2, 0, 0);
        add(0, 0, 1, 1, 20'h1E, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 20'hAA, 1, 1, 20'hAA, 1, 0, 0);
        add(1, 20'hBB, 1, 1, 20'hBB, 1, 0, 0);
        add(1, 20'hCC, 0, 1, 20'hBB, 2, 0, 0);
        add(1, 20'hDD, 0, 1, 20'hBB, 3, 0, 0);
        add(1, 20'hEE, 0, 1, 20'hBB, 4, 0, 0);
        add(1, 20'hFFFFF, 1, 1, 20'hCC, 4, 0, 0);
        add(0, 0, 1, 1, 20'hDD, 3, 0, 0);
        add(0, 0, 1, 1, 20'hEE, 2, 0, 0);
        add(0, 0, 1, 1, 20'hFFFFF, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 20'hA, 0, 1, 20'hA, 1, 0, 0);
        add(1, 20'hB, 0, 1, 20'hA, 2, 0, 0);
        add(1, 20'hC, 0, 1, 20'hA, 3, 0, 0);
        add(1, 20'hD, 0, 1, 20'hA, 4, 0, 0);
        add(1, 20'h666, 0, 1, 20'hA, 4, 1, 1);
        add(1, 20'h667, 0, 1, 20'hA, 4, 1, 2);
        add(1, 20'h668, 0, 1, 20'hA, 4, 1, 3);
        add(0, 0, 1, 1, 20'hB, 3, 1, 3);
        add(0, 0, 1, 1, 20'hC, 2, 1, 3);
        add(0, 0, 1, 1, 20'hD, 1, 1, 3);
        add(0, 0, 1, 0, 0, 0, 1, 3);

        for (int i = 0; i < vq.size(); i++) begin
            drive(0, vq[i].iv, vq[i].d, vq[i].rdy);
            step();
            chk_all($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].ec, vq[i].eo, vq[i].edr);
        end

        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 20'h300 + 20'(i), 0);
            step();
        end
        chk_all("pre_reset", 1, 20'h300, 3, 1, 3);
        drive(1, 1, 20'h123, 0);
        step();
        chk_all("mid_reset", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1);
        step();
        chk_all("after_reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 20'h500 + 20'(i), 0);
            step();
        end
        for (int i = 0; i < 254; i++) begin
            drive(0, 1, 20'hBAD00 + 20'(i), 0);
            step();
        end
        chk_all("drop254", 1, 20'h500, 4, 1, 8'hFE);
        for (int i = 0; i < 46; i++) begin
            drive(0, 1, 20'hBEE00 + 20'(i), 0);
            step();
        end
        chk_all("drop300", 1, 20'h500, 4, 1, 8'hFF);
        drive(1, 0, 0, 0);
        step();
        chk_all("reset2", 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 20'(i * 7 + 3), 1);
            step();
            chk($sformatf("wrap%0d out_data", i), 32'(out_data), 32'(i * 7 + 3));
            chk($sformatf("wrap%0d count", i), 32'(count), 32'd1);
        end
        drive(0, 0, 0, 1);
        step();
        chk_all("wrap_end", 0, 0, 0, 0, 0);

        mq.delete();
        m_ovf = 0;
        m_drop = 0;
        for (int i = 0; i < 600; i++) begin
            logic rst, iv, rdy, rd;
            logic [19:0] d;
            rst = ($urandom_range(0, 63) == 0);
            iv  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < (i < 300 ? 3 : 6));
            d   = 20'($urandom);
            drive(rst, iv, d, rdy);
            rd = (mq.size() > 0) && rdy;
            if (rst) begin
                mq.delete();
                m_ovf = 0;
                m_drop = 0;
            end else begin
                if (rd) void'(mq.pop_front());
                if (iv && (mq.size() < 4)) mq.push_back(d);
                else if (iv) begin
                    m_ovf = 1;
                    if (m_drop != 8'hFF) m_drop++;
                end
            end
            step();
            chk_all($sformatf("rnd%0d", i), mq.size() > 0, mq.size() > 0 ? mq[0] : 20'h0,
                    3'(mq.size()), m_ovf, m_drop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
